// File: rtl/evm_pkg.sv
// evm_pkg: shared constants and the FSM state encoding for the result reader.
//   NUM_CAND  - number of candidates in a tally (A..D)
//   COUNT_W   - width of each candidate tally
//   FRAME_HDR - first byte of every result frame
//   evm_state_e - reader FSM states
package evm_pkg;

  localparam int NUM_CAND = 4;
  localparam int COUNT_W = 4;
  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } evm_state_e;

endpackage

// File: rtl/evm_tx_byte.sv
// evm_tx_byte: single output byte register with valid/ready hold.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   load_i       - capture data_i as the next presented byte
//   data_i       - byte to present
//   ready_i      - downstream accepts the presented byte
//   valid_o      - a byte is presented
//   data_o       - presented byte (held stable until accepted)
//   can_load_o   - register is empty or being emptied this cycle
//   accept_o     - the presented byte transfers this cycle
module evm_tx_byte (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       can_load_o,
  output logic       accept_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  assign accept_o   = valid_q & ready_i;
  // Loading while the current byte transfers keeps one byte per cycle.
  assign can_load_o = ~valid_q | ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i && can_load_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (accept_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/evm_result_reader.sv
// evm_result_reader: snapshots four vote tallies on request, scans them for
// the leading candidate(s) one per cycle, then streams a result frame
// through a valid/ready byte interface.
// Frame: A5, {k,2'b00,count_k} for k=0..3, {tie,3'b000,winner}
//        [, XOR of the previous six bytes when EVM_RESULT_CHECKSUM_EN is defined]
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   result_req          - readout request (accepted only in IDLE)
//   vote_count_A..D     - live tallies, captured at the request
//   out_ready           - downstream accepts byte
//   out_valid, out_data - frame byte stream
//   busy                - FSM not in IDLE
//   done                - one-cycle pulse after the last byte transfers
//   winner, tie         - leading candidate(s) of the latest scan
module evm_result_reader
  import evm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               result_req,
  input  logic [COUNT_W-1:0] vote_count_A,
  input  logic [COUNT_W-1:0] vote_count_B,
  input  logic [COUNT_W-1:0] vote_count_C,
  input  logic [COUNT_W-1:0] vote_count_D,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic               busy,
  output logic               done,
  output logic [NUM_CAND-1:0] winner,
  output logic               tie
);

`ifdef EVM_RESULT_CHECKSUM_EN
  localparam logic [2:0] FRAME_LEN = 3'd7;
`else
  localparam logic [2:0] FRAME_LEN = 3'd6;
`endif

  evm_state_e                        state_q, state_d;
  logic [2:0]                        idx_q, idx_d;
  logic [NUM_CAND-1:0][COUNT_W-1:0]  snap_q, snap_d;
  logic [COUNT_W-1:0]                max_q, max_d;
  logic [NUM_CAND-1:0]               scan_win_q, scan_win_d;
  logic [NUM_CAND-1:0]               winner_q, winner_d;
  logic                              tie_q, tie_d;

  logic                              tx_load, tx_can_load, tx_accept;
  logic [7:0]                        frame_byte;
  logic [1:0]                        cand_k;
  logic [COUNT_W-1:0]                scan_cnt;
  logic [NUM_CAND-1:0]               scan_bit;

  assign cand_k   = 2'(idx_q - 3'd1);
  assign scan_cnt = snap_q[idx_q[1:0]];

  always_comb begin
    scan_bit = '0;
    scan_bit[idx_q[1:0]] = 1'b1;
  end

`ifdef EVM_RESULT_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = FRAME_HDR ^ {tie_q, 3'b000, winner_q};
    for (int k = 0; k < NUM_CAND; k++) begin
      csum = csum ^ {2'(k), 2'b00, snap_q[k]};
    end
  end
`endif

  // Byte selected by the send index; candidate bytes carry their own index.
  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      3'd0:                   frame_byte = FRAME_HDR;
      3'd1, 3'd2, 3'd3, 3'd4: frame_byte = {cand_k, 2'b00, snap_q[cand_k]};
      3'd5:                   frame_byte = {tie_q, 3'b000, winner_q};
`ifdef EVM_RESULT_CHECKSUM_EN
      3'd6:                   frame_byte = csum;
`endif
      default:                frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    max_d      = max_q;
    scan_win_d = scan_win_q;
    winner_d   = winner_q;
    tie_d      = tie_q;
    tx_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (result_req) begin
          snap_d     = {vote_count_D, vote_count_C, vote_count_B, vote_count_A};
          max_d      = '0;
          scan_win_d = '0;
          idx_d      = 3'd0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // Strictly greater takes the lead; an equal nonzero tally joins it.
        if (scan_cnt > max_q) begin
          max_d      = scan_cnt;
          scan_win_d = scan_bit;
        end else if ((scan_cnt == max_q) && (scan_cnt != '0)) begin
          scan_win_d = scan_win_q | scan_bit;
        end
        if (idx_q == 3'd3) begin
          winner_d = scan_win_d;
          tie_d    = ($countones(scan_win_d) > 1);
          idx_d    = 3'd0;
          state_d  = SEND;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      SEND: begin
        // idx_q == FRAME_LEN means the last byte is loaded and awaits transfer.
        if (idx_q < FRAME_LEN) begin
          if (tx_can_load) begin
            tx_load = 1'b1;
            idx_d   = idx_q + 3'd1;
          end
        end else if (tx_accept) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      snap_q     <= '0;
      max_q      <= '0;
      scan_win_q <= '0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      max_q      <= max_d;
      scan_win_q <= scan_win_d;
      winner_q   <= winner_d;
      tie_q      <= tie_d;
    end
  end

  evm_tx_byte u_tx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tx_load),
    .data_i     (frame_byte),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .can_load_o (tx_can_load),
    .accept_o   (tx_accept)
  );

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign winner = winner_q;
  assign tie    = tie_q;

endmodule

// File: tb/tb_evm_result_reader.sv
// Testbench for evm_result_reader: directed and randomized frames checked
// against a frame model computed from the tallies.
module tb_evm_result_reader;

`ifdef EVM_RESULT_CHECKSUM_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  logic       clk, rst, result_req, out_ready;
  logic [3:0] vote_count_A, vote_count_B, vote_count_C, vote_count_D;
  logic       out_valid, busy, done, tie;
  logic [7:0] out_data;
  logic [3:0] winner;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_frame [7];
  logic [3:0] exp_win;
  logic       exp_tie;

  evm_result_reader dut (
    .clk          (clk),
    .rst          (rst),
    .result_req   (result_req),
    .vote_count_A (vote_count_A),
    .vote_count_B (vote_count_B),
    .vote_count_C (vote_count_C),
    .vote_count_D (vote_count_D),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .tie          (tie)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: winners are every candidate holding the (nonzero) maximum.
  task automatic model(input logic [3:0] a, b, c, d);
    int cnt [4];
    int mx;
    logic [7:0] x;
    cnt = '{int'(a), int'(b), int'(c), int'(d)};
    mx = 0;
    for (int k = 0; k < 4; k++) if (cnt[k] > mx) mx = cnt[k];
    exp_win = 4'b0000;
    if (mx != 0) for (int k = 0; k < 4; k++) if (cnt[k] == mx) exp_win[k] = 1'b1;
    exp_tie = ($countones(exp_win) > 1);
    exp_frame[0] = 8'hA5;
    for (int k = 0; k < 4; k++) exp_frame[k+1] = 8'(k * 64 + cnt[k]);
    exp_frame[5] = 8'((exp_tie ? 128 : 0) + int'(exp_win));
    x = 8'h00;
    for (int k = 0; k < 6; k++) x = x ^ exp_frame[k];
    exp_frame[6] = x;
  endtask

  task automatic do_frame(input string name, input logic [3:0] a, b, c, d,
                          input int ready_pct, input int stall_at,
                          input bit req_busy, input bit req_in_done, input bit mutate);
    int lat, got, cyc, stall_cnt, bad;
    bit prev_stall;
    logic [7:0] prev_data;
    model(a, b, c, d);
    vote_count_A = a; vote_count_B = b; vote_count_C = c; vote_count_D = d;
    result_req = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    result_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_req: got %b expected 1", name, busy);
    end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      result_req = (req_busy && lat == 2);
      if (mutate) begin
        vote_count_A = 4'd9;
        vote_count_C = 4'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    result_req = 1'b0;
    checks++;
    if (lat != 6) begin
      failures++;
      $display("FAIL %s first_valid_latency: got %0d expected 6", name, lat);
      return;
    end
    got = 0; cyc = 0; stall_cnt = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (got < FLEN && cyc < 300) begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          failures++;
          $display("FAIL %s hold_stable: got valid=%b data=%h expected valid=1 data=%h",
                   name, out_valid, out_data, prev_data);
        end
      end
      if (mutate) begin
        vote_count_A = 4'd9;
        vote_count_B = 4'($urandom);
      end
      result_req = (req_busy && cyc == 1);
      out_ready = ($urandom_range(99) < ready_pct);
      if (got == stall_at && stall_cnt < 3 && out_valid === 1'b1) begin
        out_ready = 1'b0;
        stall_cnt++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_data !== exp_frame[got]) begin
          failures++;
          $display("FAIL %s byte%0d: got %h expected %h", name, got, out_data, exp_frame[got]);
        end
        got++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = (out_valid === 1'b1);
      end
      prev_data = out_data;
      @(negedge clk);
      cyc++;
    end
    result_req = 1'b0;
    if (got < FLEN) begin
      checks++;
      failures++;
      $display("FAIL %s frame_timeout: got %0d bytes expected %0d", name, got, FLEN);
      return;
    end
    if (ready_pct == 100 && stall_at < 0) begin
      checks++;
      if (cyc != FLEN) begin
        failures++;
        $display("FAIL %s back_to_back_cycles: got %0d expected %0d", name, cyc, FLEN);
      end
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: got done=%b valid=%b expected done=1 valid=0", name, done, out_valid);
    end
    checks++;
    if (winner !== exp_win || tie !== exp_tie) begin
      failures++;
      $display("FAIL %s winner_tie: got %b/%b expected %b/%b", name, winner, tie, exp_win, exp_tie);
    end
    result_req = req_in_done;
    out_ready = $urandom_range(1);
    @(negedge clk);
    result_req = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s back_to_idle: got done=%b busy=%b expected 0/0", name, done, busy);
    end
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s no_queued_frame: got %0d busy/valid cycles expected 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    result_req = 1'b0;
    out_ready = 1'b0;
    vote_count_A = 4'd0; vote_count_B = 4'd0; vote_count_C = 4'd0; vote_count_D = 4'd0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
        winner !== 4'b0000 || tie !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h b=%b dn=%b w=%b t=%b expected all zero",
               out_valid, out_data, busy, done, winner, tie);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b expected 0/0", busy, out_valid);
    end
  endtask

  task automatic test_directed();
    do_frame("basic_2101", 4'd2, 4'd1, 4'd0, 4'd1, 100, -1, 1'b0, 1'b0, 1'b0);
    do_frame("tie_3310", 4'd3, 4'd3, 4'd1, 4'd0, 100, -1, 1'b0, 1'b0, 1'b0);
    do_frame("all_zero", 4'd0, 4'd0, 4'd0, 4'd0, 100, -1, 1'b0, 1'b0, 1'b0);
    do_frame("all_max", 4'd15, 4'd15, 4'd15, 4'd15, 100, -1, 1'b0, 1'b0, 1'b0);
    do_frame("a_only_max", 4'd15, 4'd0, 4'd0, 4'd0, 100, -1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_stall_and_busy_req();
    do_frame("stall_byte2", 4'd2, 4'd1, 4'd0, 4'd1, 100, 2, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_snapshot();
    do_frame("snapshot_hold", 4'd4, 4'd6, 4'd2, 4'd6, 100, -1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    vote_count_A = 4'd5; vote_count_B = 4'd7; vote_count_C = 4'd7; vote_count_D = 4'd2;
    result_req = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    result_req = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_frame_precondition: got busy=%b valid=%b expected 1/1", busy, out_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
        winner !== 4'b0000 || tie !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_mid: got v=%b d=%h b=%b dn=%b w=%b t=%b expected all zero",
               out_valid, out_data, busy, done, winner, tie);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL no_partial_after_reset: got %0d active cycles expected 0", bad);
    end
    do_frame("fresh_after_reset", 4'd5, 4'd7, 4'd7, 4'd2, 100, -1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_frame("random", 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               40 + int'($urandom_range(60)), -1, 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_and_busy_req();
    test_snapshot();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
